// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: in-order, single-instruction fetch sequencer.
//
// This block issues fetch requests one instruction at a time, in order. Each
// response is written into the 48-entry instruction buffer as {instr, pc}.
// The number of requests in flight is limited by the free space in the buffer,
// so the buffer can never overflow. On a redirect, every request still in
// flight becomes stale. The block discards those responses, then restarts
// fetching at the redirect target.
//
// Ports
//   clock            : single clock, rising edge
//   reset_n          : asynchronous, active-low reset
//   fetch_enable     : level signal; allows new requests to issue
//   redirect_valid   : one-cycle pulse; flush and restart at redirect_target
//   redirect_target  : new fetch PC (4-byte aligned)
//   fetch_req_valid  : request offered to memory
//   fetch_req_ready  : memory accepts the request
//   fetch_req_addr   : PC of the offered request
//   fetch_resp_valid : in-order response, one per accepted request
//   fetch_resp_data  : instruction word of the response
//   ibuf_count       : current instruction-buffer occupancy
//   ibuf_write_en    : buffer write strobe (same cycle as the live response)
//   ibuf_data_in     : [95:64] instruction, [63:0] PC
//   outst_cnt        : accepted requests still waiting for a response
//   draining         : high while stale responses are being discarded
//
// Request handshake: a request transfers on a cycle where fetch_req_valid and
// fetch_req_ready are both high. Once fetch_req_valid is raised, it stays high
// and fetch_req_addr stays stable until the transfer happens. The only
// exception is a redirect, which may withdraw the offer. fetch_enable going
// low never withdraws a request that is already being offered.

module ifetch_ctrl #(
  parameter logic [63:0] PC_RESET   = 64'h8000_0000,
  parameter int          IBUF_DEPTH = 48,
  parameter int          MAX_OUTST  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        fetch_req_valid,
  input  logic        fetch_req_ready,
  output logic [63:0] fetch_req_addr,
  input  logic        fetch_resp_valid,
  input  logic [31:0] fetch_resp_data,
  input  logic [5:0]  ibuf_count,
  output logic        ibuf_write_en,
  output logic [95:0] ibuf_data_in,
  output logic [2:0]  outst_cnt,
  output logic        draining
);

  localparam logic [2:0] OUTST_LIMIT = 3'(MAX_OUTST);
  localparam logic [6:0] DEPTH_LIMIT = 7'(IBUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] fetch_pc;
  logic [63:0] resp_pc;
  logic [2:0]  outst;
  logic [2:0]  drop;

  logic [6:0]  credit_sum;
  logic        credit_ok;
  logic        fire;
  logic        live;
  logic        stale;
  logic [2:0]  outst_nxt;

  // A request is counted against the buffer from the moment it is accepted.
  // So buffer occupancy plus in-flight requests must leave room for one more
  // entry.
  assign credit_sum = {1'b0, ibuf_count} + {4'b0, outst};
  assign credit_ok  = (outst < OUTST_LIMIT) && (credit_sum < DEPTH_LIMIT);

  assign fetch_req_valid = (state == FETCH) && credit_ok;
  assign fetch_req_addr  = fetch_pc;
  assign fire            = fetch_req_valid && fetch_req_ready;

  assign outst_nxt = outst + {2'b0, fire} - {2'b0, fetch_resp_valid};

  // A response that arrives in the redirect cycle belongs to the old path.
  // The buffer is also clearing itself in that cycle, so nothing is written.
  assign live  = fetch_resp_valid && (drop == 3'd0) && !redirect_valid;
  assign stale = fetch_resp_valid && (drop != 3'd0);

  assign ibuf_write_en = live;
  assign ibuf_data_in  = live ? {fetch_resp_data, resp_pc} : 96'd0;
  assign outst_cnt     = outst;
  assign draining      = (state == DRAIN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = DRAIN;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_enable) state_nxt = FETCH;
        end
        FETCH: begin
          if (!fetch_enable && (!fetch_req_valid || fire)) state_nxt = IDLE;
        end
        DRAIN: begin
          if (drop == 3'd0) state_nxt = fetch_enable ? FETCH : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= PC_RESET;
      resp_pc  <= PC_RESET;
      outst    <= 3'd0;
      drop     <= 3'd0;
    end else begin
      outst <= outst_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        // This includes a request accepted in this same cycle.
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop     <= outst_nxt;
      end else begin
        if (fire)  fetch_pc <= fetch_pc + 64'd4;
        if (live)  resp_pc  <= resp_pc + 64'd4;
        if (stale) drop     <= drop - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl.
// It runs in three parts:
//   1. A table of cycle-by-cycle vectors starting from reset.
//   2. Hand-written sequences for stall, redirect and mid-run reset.
//   3. A randomized run checked against a queue-based reference model.

module tb_ifetch_ctrl;

  localparam logic [63:0] P = 64'h8000_0000;
  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = 64'd0;
  logic        fetch_req_valid;
  logic        fetch_req_ready = 1'b0;
  logic [63:0] fetch_req_addr;
  logic        fetch_resp_valid = 1'b0;
  logic [31:0] fetch_resp_data = 32'd0;
  logic [5:0]  ibuf_count = 6'd0;
  logic        ibuf_write_en;
  logic [95:0] ibuf_data_in;
  logic [2:0]  outst_cnt;
  logic        draining;

  always #5 clock = ~clock;

  ifetch_ctrl dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .fetch_enable     (fetch_enable),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_ready  (fetch_req_ready),
    .fetch_req_addr   (fetch_req_addr),
    .fetch_resp_valid (fetch_resp_valid),
    .fetch_resp_data  (fetch_resp_data),
    .ibuf_count       (ibuf_count),
    .ibuf_write_en    (ibuf_write_en),
    .ibuf_data_in     (ibuf_data_in),
    .outst_cnt        (outst_cnt),
    .draining         (draining)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let them settle.
  task automatic drive(input logic en, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic [5:0] cnt,
                       input logic redir, input logic [63:0] tgt);
    @(negedge clock);
    fetch_enable     = en;
    fetch_req_ready  = rdy;
    fetch_resp_valid = rv;
    fetch_resp_data  = rd;
    ibuf_count       = cnt;
    redirect_valid   = redir;
    redirect_target  = tgt;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n          = 1'b0;
    fetch_enable     = 1'b0;
    fetch_req_ready  = 1'b0;
    fetch_resp_valid = 1'b0;
    fetch_resp_data  = 32'd0;
    ibuf_count       = 6'd0;
    redirect_valid   = 1'b0;
    redirect_target  = 64'd0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en, rdy, rv;
    logic [31:0] rd;
    logic [5:0]  cnt;
    logic        redir;
    logic [63:0] tgt;
    logic        e_val;
    logic [63:0] e_addr;
    logic        e_we;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic [2:0]  e_outst;
    logic        e_drain;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic rdy, input logic rv,
                              input logic [31:0] rd, input logic [5:0] cnt,
                              input logic redir, input logic [63:0] tgt,
                              input logic e_val, input logic [63:0] e_addr,
                              input logic e_we, input logic [31:0] e_instr,
                              input logic [63:0] e_pc, input logic [2:0] e_outst,
                              input logic e_drain);
    return '{en, rdy, rv, rd, cnt, redir, tgt, e_val, e_addr, e_we, e_instr, e_pc, e_outst, e_drain};
  endfunction

  // ---------------- reference model state (random phase) ----------------
  typedef struct packed { logic [63:0] pc; logic stale; } fl_t;
  typedef struct packed { int due; logic [31:0] data; } mr_t;

  fl_t         fl_q[$];   // accepted requests in order, with stale flag
  mr_t         mem_q[$];  // memory-side pending responses
  logic [63:0] m_pc;
  logic        m_fetch, m_drain;
  int          occ, last_due;

  initial begin
    logic        en_r, rdy_r, rv_r, redir_r, exp_valid, head_live, stale_pending, m_fire;
    logic        dut_fire, dut_we;
    logic [31:0] rd_r;
    logic [63:0] tgt_r;
    int          due, t;

    // ---- reset values ----
    #2 reset_n = 1'b0;
    @(negedge clock);
    chk("rst valid", 96'(fetch_req_valid), 96'(0));
    chk("rst addr",  96'(fetch_req_addr), 96'(P));
    chk("rst we",    96'(ibuf_write_en), 96'(0));
    chk("rst data",  ibuf_data_in, 96'd0);
    chk("rst outst", 96'(outst_cnt), 96'(0));
    chk("rst drain", 96'(draining), 96'(0));
    @(negedge clock);
    reset_n = 1'b1;

    // ---- table: startup, saturation, credit, redirect drain, disable ----
    //             en rdy rv rd            cnt    rdr tgt         | val addr          we instr         pc            out   drn
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     L, P,            L, 32'h0,        64'h0,        3'd0, L));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     H, P,            L, 32'h0,        64'h0,        3'd0, L));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     H, P + 64'h4,    L, 32'h0,        64'h0,        3'd1, L));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     H, P + 64'h8,    L, 32'h0,        64'h0,        3'd2, L));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     H, P + 64'hC,    L, 32'h0,        64'h0,        3'd3, L));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     L, P + 64'h10,   L, 32'h0,        64'h0,        3'd4, L));
    tbl.push_back(mk(H, H, H, 32'hA000_0000, 6'd0, L, 64'h0,     L, P + 64'h10,   H, 32'hA000_0000, P,           3'd4, L));
    tbl.push_back(mk(H, H, H, 32'hA000_0001, 6'd0, L, 64'h0,     H, P + 64'h10,   H, 32'hA000_0001, P + 64'h4,   3'd3, L));
    tbl.push_back(mk(H, H, H, 32'hA000_0002, 6'd0, L, 64'h0,     H, P + 64'h14,   H, 32'hA000_0002, P + 64'h8,   3'd3, L));
    tbl.push_back(mk(H, L, H, 32'hA000_0003, 6'd0, L, 64'h0,     H, P + 64'h18,   H, 32'hA000_0003, P + 64'hC,   3'd3, L));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd46, L, 64'h0,     L, P + 64'h18,   L, 32'h0,        64'h0,        3'd2, L));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd45, L, 64'h0,     H, P + 64'h18,   L, 32'h0,        64'h0,        3'd2, L));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd45, L, 64'h0,     L, P + 64'h1C,   L, 32'h0,        64'h0,        3'd3, L));
    tbl.push_back(mk(H, H, H, 32'hA000_0004, 6'd45, H, 64'h1000, L, P + 64'h1C,   L, 32'h0,        64'h0,        3'd3, L));
    tbl.push_back(mk(H, H, H, 32'hA000_0005, 6'd0, L, 64'h0,     L, 64'h1000,     L, 32'h0,        64'h0,        3'd2, H));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     L, 64'h1000,     L, 32'h0,        64'h0,        3'd1, H));
    tbl.push_back(mk(H, H, H, 32'hA000_0006, 6'd0, L, 64'h0,     L, 64'h1000,     L, 32'h0,        64'h0,        3'd1, H));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     L, 64'h1000,     L, 32'h0,        64'h0,        3'd0, H));
    tbl.push_back(mk(H, H, L, 32'h0,        6'd0,  L, 64'h0,     H, 64'h1000,     L, 32'h0,        64'h0,        3'd0, L));
    tbl.push_back(mk(H, L, L, 32'h0,        6'd0,  L, 64'h0,     H, 64'h1004,     L, 32'h0,        64'h0,        3'd1, L));
    tbl.push_back(mk(H, H, H, 32'hA000_0007, 6'd0, L, 64'h0,     H, 64'h1004,     H, 32'hA000_0007, 64'h1000,    3'd1, L));
    tbl.push_back(mk(L, L, L, 32'h0,        6'd0,  L, 64'h0,     H, 64'h1008,     L, 32'h0,        64'h0,        3'd1, L));
    tbl.push_back(mk(L, L, L, 32'h0,        6'd0,  L, 64'h0,     H, 64'h1008,     L, 32'h0,        64'h0,        3'd1, L));
    tbl.push_back(mk(L, H, L, 32'h0,        6'd0,  L, 64'h0,     H, 64'h1008,     L, 32'h0,        64'h0,        3'd1, L));
    tbl.push_back(mk(L, H, H, 32'hA000_0008, 6'd0, L, 64'h0,     L, 64'h100C,     H, 32'hA000_0008, 64'h1004,    3'd2, L));
    tbl.push_back(mk(L, H, H, 32'hA000_0009, 6'd0, L, 64'h0,     L, 64'h100C,     H, 32'hA000_0009, 64'h1008,    3'd1, L));
    tbl.push_back(mk(L, H, L, 32'h0,        6'd0,  L, 64'h0,     L, 64'h100C,     L, 32'h0,        64'h0,        3'd0, L));
    tbl.push_back(mk(L, H, L, 32'h0,        6'd0,  L, 64'h0,     L, 64'h100C,     L, 32'h0,        64'h0,        3'd0, L));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].cnt, tbl[i].redir, tbl[i].tgt);
      chk($sformatf("t%0d valid", i), 96'(fetch_req_valid), 96'(tbl[i].e_val));
      chk($sformatf("t%0d addr", i),  96'(fetch_req_addr),  96'(tbl[i].e_addr));
      chk($sformatf("t%0d we", i),    96'(ibuf_write_en),   96'(tbl[i].e_we));
      if (tbl[i].e_we) chk($sformatf("t%0d data", i), ibuf_data_in, {tbl[i].e_instr, tbl[i].e_pc});
      chk($sformatf("t%0d outst", i), 96'(outst_cnt), 96'(tbl[i].e_outst));
      chk($sformatf("t%0d drain", i), 96'(draining),  96'(tbl[i].e_drain));
    end

    // ---- ready held low for 5 cycles: offer held, then exactly one fire ----
    do_reset();
    drive(H, L, L, 32'h0, 6'd0, L, 64'h0);
    chk("stall idle valid", 96'(fetch_req_valid), 96'(0));
    for (int i = 0; i < 5; i++) begin
      drive(H, L, L, 32'h0, 6'd0, L, 64'h0);
      chk($sformatf("stall%0d valid", i), 96'(fetch_req_valid), 96'(1));
      chk($sformatf("stall%0d addr", i),  96'(fetch_req_addr), 96'(P));
    end
    drive(H, H, L, 32'h0, 6'd0, L, 64'h0);
    chk("stall fire addr", 96'(fetch_req_addr), 96'(P));
    drive(H, L, L, 32'h0, 6'd0, L, 64'h0);
    chk("stall next addr", 96'(fetch_req_addr), 96'(P + 64'h4));
    chk("stall outst a", 96'(outst_cnt), 96'(1));
    drive(H, L, L, 32'h0, 6'd0, L, 64'h0);
    chk("stall outst b", 96'(outst_cnt), 96'(1));

    // ---- redirect together with fire and response at outst=2 ----
    do_reset();
    drive(H, H, L, 32'h0, 6'd0, L, 64'h0);
    drive(H, H, L, 32'h0, 6'd0, L, 64'h0);
    drive(H, H, L, 32'h0, 6'd0, L, 64'h0);
    drive(H, H, H, 32'hB000_0000, 6'd0, H, 64'h2000);
    chk("rfr valid", 96'(fetch_req_valid), 96'(1));
    chk("rfr outst", 96'(outst_cnt), 96'(2));
    chk("rfr we", 96'(ibuf_write_en), 96'(0));
    drive(H, H, H, 32'hB000_0001, 6'd0, L, 64'h0);
    chk("rfr drain", 96'(draining), 96'(1));
    chk("rfr stale1 we", 96'(ibuf_write_en), 96'(0));
    drive(H, H, H, 32'hB000_0002, 6'd0, L, 64'h0);
    chk("rfr stale2 we", 96'(ibuf_write_en), 96'(0));
    chk("rfr outst1", 96'(outst_cnt), 96'(1));
    drive(H, H, L, 32'h0, 6'd0, L, 64'h0);
    chk("rfr drain end", 96'(draining), 96'(1));
    chk("rfr hold valid", 96'(fetch_req_valid), 96'(0));
    drive(H, H, L, 32'h0, 6'd0, L, 64'h0);
    chk("rfr new addr", 96'(fetch_req_addr), 96'(64'h2000));
    chk("rfr new valid", 96'(fetch_req_valid), 96'(1));
    drive(H, L, H, 32'hB000_0003, 6'd0, L, 64'h0);
    chk("rfr live we", 96'(ibuf_write_en), 96'(1));
    chk("rfr live data", ibuf_data_in, {32'hB000_0003, 64'h2000});

    // ---- asynchronous reset while draining ----
    drive(H, H, L, 32'h0, 6'd0, L, 64'h0);
    drive(H, L, L, 32'h0, 6'd0, H, 64'h3000);
    drive(H, L, L, 32'h0, 6'd0, L, 64'h0);
    chk("pre-rst drain", 96'(draining), 96'(1));
    chk("pre-rst outst", 96'(outst_cnt), 96'(1));
    fetch_enable = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("async drain", 96'(draining), 96'(0));
    chk("async outst", 96'(outst_cnt), 96'(0));
    chk("async valid", 96'(fetch_req_valid), 96'(0));
    chk("async addr", 96'(fetch_req_addr), 96'(P));
    chk("async we", 96'(ibuf_write_en), 96'(0));
    @(negedge clock);
    reset_n = 1'b1;

    // ---- randomized run against the reference model ----
    do_reset();
    fl_q.delete();
    mem_q.delete();
    m_pc = P; m_fetch = 1'b0; m_drain = 1'b0;
    occ = 0; last_due = -1; en_r = 1'b1;
    for (t = 0; t < 4000; t++) begin
      if (en_r) en_r = ($urandom_range(0, 29) != 0);
      else      en_r = ($urandom_range(0, 3) == 0);
      rdy_r   = ($urandom_range(0, 3) != 0);
      redir_r = ((t / 500) % 2 == 1) ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 29) == 0);
      tgt_r   = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom & 32'hFFFF_FFFC};
      rv_r    = (mem_q.size() > 0) && (mem_q[0].due <= t);
      rd_r    = rv_r ? mem_q[0].data : $urandom;
      drive(en_r, rdy_r, rv_r, rd_r, 6'(occ), redir_r, tgt_r);

      exp_valid = m_fetch && (fl_q.size() < 4) && (occ + fl_q.size() < 48);
      head_live = rv_r && !redir_r && (fl_q.size() > 0) && !fl_q[0].stale;
      chk($sformatf("r%0d valid", t), 96'(fetch_req_valid), 96'(exp_valid));
      chk($sformatf("r%0d addr", t), 96'(fetch_req_addr), 96'(m_pc));
      chk($sformatf("r%0d outst", t), 96'(outst_cnt), 96'(fl_q.size()));
      chk($sformatf("r%0d drain", t), 96'(draining), 96'(m_drain));
      chk($sformatf("r%0d we", t), 96'(ibuf_write_en), 96'(head_live));
      if (head_live) chk($sformatf("r%0d data", t), ibuf_data_in, {rd_r, fl_q[0].pc});
      chk($sformatf("r%0d credit", t), 96'(occ + int'(outst_cnt) <= 48), 96'(1));

      // model update for this edge
      stale_pending = 1'b0;
      foreach (fl_q[k]) if (fl_q[k].stale) stale_pending = 1'b1;
      m_fire = exp_valid && rdy_r;
      if (rv_r && fl_q.size() > 0) void'(fl_q.pop_front());
      if (m_fire) begin
        fl_q.push_back('{pc: m_pc, stale: redir_r});
        m_pc = m_pc + 64'd4;
      end
      if (redir_r) begin
        foreach (fl_q[k]) fl_q[k].stale = 1'b1;
        m_pc = tgt_r; m_fetch = 1'b0; m_drain = 1'b1;
      end else if (m_drain) begin
        if (!stale_pending) begin m_drain = 1'b0; m_fetch = en_r; end
      end else if (m_fetch) begin
        if (!en_r && (!exp_valid || m_fire)) m_fetch = 1'b0;
      end else if (en_r) begin
        m_fetch = 1'b1;
      end

      // environment: memory returns in order, buffer fills and drains
      dut_fire = fetch_req_valid && rdy_r;
      dut_we   = ibuf_write_en;
      if (rv_r) void'(mem_q.pop_front());
      if (dut_fire) begin
        due = t + (($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(1, 3)));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{due: due, data: $urandom});
      end
      if (redir_r) occ = 0;
      else if (dut_we) occ = occ + 1;
      if (occ > 63) occ = 63;
      if (occ > 0 && (((t / 500) % 2 == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0)))
        occ = occ - 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
